target_hit_detector: RTL and testbench

TARGET_HIT_DETECTOR -- requirements
Module: target_hit_detector

---
 rtl/target_hit_detector.sv | 132 +++++++++++++
 tb/tb_target_hit_detector.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/target_hit_detector.sv
// Photo-target hit detector: synchronizes and debounces 10 photo bits, arms one target
// for a timed window and reports hit/miss with a saturating score. Define MISS_PENALTY_EN to deduct a point per miss.
module target_hit_detector #(
    parameter int          DEB_CYCLES = 8,
    parameter logic [31:0] HIT_POINTS = 32'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  photo_array,
    input  logic        arm,
    input  logic [3:0]  target_id,
    input  logic [31:0] window_len,
    output logic        busy,
    output logic        arm_err,
    output logic        res_valid,
    input  logic        res_ack,
    output logic        res_hit,
    output logic [3:0]  res_target,
    output logic [31:0] score
);

    localparam int NT = 10;
    localparam int CW = 8;

    typedef enum logic [1:0] {IDLE, ARMED, REPORT} state_t;

    state_t        state;
    logic [3:0]    tgt_q;
    logic [31:0]   win_cnt;
    logic [NT-1:0] sync_p0, sync_p1;
    logic [CW-1:0] deb_cnt [NT];
    logic [NT-1:0] lit, lit_q;
    logic [15:0]   rise_all;
    logic          hit_edge;

    function automatic logic [31:0] sat_add(input logic [31:0] a);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, HIT_POINTS};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [31:0] miss_score(input logic [31:0] a);
`ifdef MISS_PENALTY_EN
        return (a == 32'd0) ? a : a - 32'd1;
`else
        return a;
`endif
    endfunction

    always_comb begin
        for (int i = 0; i < NT; i++) lit[i] = (deb_cnt[i] == CW'(DEB_CYCLES));
    end

    // Padded so any 4-bit latched index selects a defined bit.
    assign rise_all = {6'b0, lit & ~lit_q};
    assign hit_edge = rise_all[tgt_q];
    assign busy     = (state != IDLE);

    // Stage p0/p1: two-flop synchronizer, then per-bit saturating debounce counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            lit_q   <= '0;
            for (int i = 0; i < NT; i++) deb_cnt[i] <= '0;
        end else begin
            sync_p0 <= photo_array;
            sync_p1 <= sync_p0;
            lit_q   <= lit;
            for (int i = 0; i < NT; i++) begin
                if (!sync_p1[i])
                    deb_cnt[i] <= '0;
                else if (!lit[i])
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end

    // Control FSM; a hit edge takes priority over window expiry in the same cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tgt_q      <= '0;
            win_cnt    <= '0;
            arm_err    <= 1'b0;
            res_valid  <= 1'b0;
            res_hit    <= 1'b0;
            res_target <= '0;
            score      <= '0;
        end else begin
            arm_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        if (target_id <= 4'd9) begin
                            tgt_q   <= target_id;
                            win_cnt <= (window_len == 32'd0) ? 32'd1 : window_len;
                            state   <= ARMED;
                        end else begin
                            arm_err <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (hit_edge) begin
                        state      <= REPORT;
                        res_valid  <= 1'b1;
                        res_hit    <= 1'b1;
                        res_target <= tgt_q;
                        score      <= sat_add(score);
                    end else if (win_cnt == 32'd0) begin
                        state      <= REPORT;
                        res_valid  <= 1'b1;
                        res_hit    <= 1'b0;
                        res_target <= tgt_q;
                        score      <= miss_score(score);
                    end else begin
                        win_cnt <= win_cnt - 32'd1;
                    end
                end
                REPORT: begin
                    if (res_ack) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_target_hit_detector.sv
// Scoreboard bench for target_hit_detector: a second instance with a huge HIT_POINTS
// exercises score saturation alongside the main instance.
module tb_target_hit_detector;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  photo_array;
    logic        arm;
    logic [3:0]  target_id;
    logic [31:0] window_len;
    logic        res_ack;
    logic        busy, arm_err, res_valid, res_hit;
    logic [3:0]  res_target;
    logic [31:0] score;
    logic        busy2, arm_err2, res_valid2, res_hit2;
    logic [3:0]  res_target2;
    logic [31:0] score2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic        hit;
        logic [3:0]  tgt;
        logic [31:0] s1;
        logic [31:0] s2;
    } exp_t;
    exp_t q[$];
    logic [31:0] sc1 = 32'd0;
    logic [31:0] sc2 = 32'd0;

    target_hit_detector #(.DEB_CYCLES(8), .HIT_POINTS(32'd1)) dut (
        .clock(clock), .reset(reset), .photo_array(photo_array), .arm(arm),
        .target_id(target_id), .window_len(window_len), .busy(busy), .arm_err(arm_err),
        .res_valid(res_valid), .res_ack(res_ack), .res_hit(res_hit),
        .res_target(res_target), .score(score)
    );

    target_hit_detector #(.DEB_CYCLES(8), .HIT_POINTS(32'hFFFF_FFFF)) dut_sat (
        .clock(clock), .reset(reset), .photo_array(photo_array), .arm(arm),
        .target_id(target_id), .window_len(window_len), .busy(busy2), .arm_err(arm_err2),
        .res_valid(res_valid2), .res_ack(res_ack), .res_hit(res_hit2),
        .res_target(res_target2), .score(score2)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    task automatic exp_hit(input logic [3:0] t);
        exp_t e;
        sc1 = sat_add(sc1, 32'd1);
        sc2 = sat_add(sc2, 32'hFFFF_FFFF);
        e.hit = 1'b1; e.tgt = t; e.s1 = sc1; e.s2 = sc2;
        q.push_back(e);
    endtask

    task automatic exp_miss(input logic [3:0] t);
        exp_t e;
`ifdef MISS_PENALTY_EN
        if (sc1 != 0) sc1 = sc1 - 1;
        if (sc2 != 0) sc2 = sc2 - 1;
`endif
        e.hit = 1'b0; e.tgt = t; e.s1 = sc1; e.s2 = sc2;
        q.push_back(e);
    endtask

    // Monitor: compare each newly presented result against the scoreboard head.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev = 1'b0;
            end else begin
                if (res_valid && !prev) begin
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_result: got target %0d hit %0b, expected none", res_target, res_hit);
                    end else begin
                        e = q.pop_front();
                        chk("res_hit", 64'(res_hit), 64'(e.hit));
                        chk("res_target", 64'(res_target), 64'(e.tgt));
                        chk("score", 64'(score), 64'(e.s1));
                        chk("score_sat", 64'(score2), 64'(e.s2));
                    end
                end
                prev = res_valid;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic arm_tgt(input logic [3:0] t, input logic [31:0] len, output int acyc);
        @(negedge clock);
        arm = 1'b1; target_id = t; window_len = len;
        @(negedge clock);
        arm = 1'b0;
        acyc = cyc;
    endtask

    task automatic wait_valid(input string name, input int ref_cyc, input int exp_lat);
        int n;
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!res_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no res_valid within 200 cycles, expected latency %0d", name, exp_lat);
        end else begin
            chk(name, 64'(cyc - ref_cyc), 64'(exp_lat));
        end
    endtask

    task automatic ack;
        @(negedge clock);
        res_ack = 1'b1;
        @(negedge clock);
        res_ack = 1'b0;
        chk("ack_valid", 64'(res_valid), 64'd0);
        chk("ack_busy", 64'(busy), 64'd0);
    endtask

    task automatic set_photo(input int b, input logic v, output int pcyc);
        photo_array[b] = v;
        pcyc = cyc;
    endtask

    initial begin
        int a, p;
        logic ok;
        reset = 1'b0; photo_array = '0; arm = 1'b0; target_id = '0;
        window_len = '0; res_ack = 1'b0;
        tick(3);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_score", 64'(score), 64'd0);

        // Arm accepted on the first edge after reset release; miss after window 5
        @(negedge clock);
        reset = 1'b1; arm = 1'b1; target_id = 4'd7; window_len = 32'd5;
        @(negedge clock);
        arm = 1'b0; a = cyc;
        chk("first_arm_busy", 64'(busy), 64'd1);
        exp_miss(4'd7);
        wait_valid("miss_lat", a, 6);
        ack();

        // Two hits on target 3, then a miss with score at 2
        for (int k = 0; k < 2; k++) begin
            arm_tgt(4'd3, 32'd100, a);
            tick(2);
            exp_hit(4'd3);
            set_photo(3, 1'b1, p);
            wait_valid("hit_lat", p, 11);
            ack();
            photo_array[3] = 1'b0;
            tick(4);
        end
        arm_tgt(4'd7, 32'd5, a);
        exp_miss(4'd7);
        wait_valid("miss2_lat", a, 6);
        ack();

        // 7-cycle pulse on the armed bit and a lit wrong target: window expires
        arm_tgt(4'd3, 32'd40, a);
        tick(2);
        photo_array[3] = 1'b1;
        tick(7);
        photo_array[3] = 1'b0;
        tick(3);
        photo_array[5] = 1'b1;
        tick(20);
        chk("debounce_nohit", 64'(res_valid), 64'd0);
        exp_miss(4'd3);
        wait_valid("deb_miss_lat", a, 41);
        ack();
        photo_array[5] = 1'b0;
        tick(4);

        // Already lit at arm time: only a relight counts
        photo_array[3] = 1'b1;
        tick(12);
        arm_tgt(4'd3, 32'd60, a);
        tick(20);
        chk("prelit_nohit", 64'(res_valid), 64'd0);
        photo_array[3] = 1'b0;
        tick(4);
        exp_hit(4'd3);
        set_photo(3, 1'b1, p);
        wait_valid("relight_lat", p, 11);
        ack();
        photo_array[3] = 1'b0;
        tick(4);

        // Rejected arm in IDLE
        @(negedge clock);
        arm = 1'b1; target_id = 4'd12; window_len = 32'd5;
        @(negedge clock);
        arm = 1'b0;
        chk("rej_err", 64'(arm_err), 64'd1);
        chk("rej_busy", 64'(busy), 64'd0);
        @(negedge clock);
        chk("rej_err_pulse", 64'(arm_err), 64'd0);

        // Arms while ARMED are ignored
        arm_tgt(4'd2, 32'd10, a);
        tick(1);
        @(negedge clock);
        arm = 1'b1; target_id = 4'd12;
        @(negedge clock);
        chk("armed_no_err", 64'(arm_err), 64'd0);
        target_id = 4'd5; window_len = 32'd1;
        @(negedge clock);
        arm = 1'b0;
        chk("armed_busy", 64'(busy), 64'd1);
        exp_miss(4'd2);
        wait_valid("ign_arm_lat", a, 11);
        ack();

        // Hit edge in the expiry cycle: hit wins
        arm_tgt(4'd8, 32'd20, a);
        tick(10);
        exp_hit(4'd8);
        photo_array[8] = 1'b1;
        wait_valid("tie_lat", a, 21);
        ack();
        photo_array[8] = 1'b0;
        tick(4);

        // Stray ack in IDLE, then hit on 4 held for 50 cycles with a stray arm
        @(negedge clock);
        res_ack = 1'b1;
        @(negedge clock);
        res_ack = 1'b0;
        chk("stray_ack_busy", 64'(busy), 64'd0);
        arm_tgt(4'd4, 32'd60, a);
        exp_hit(4'd4);
        set_photo(4, 1'b1, p);
        wait_valid("hold_lat", p, 11);
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            arm = (i == 10);
            target_id = 4'd12;
            if (!(res_valid === 1'b1 && res_hit === 1'b1 && res_target === 4'd4 &&
                  score === sc1 && arm_err === 1'b0 && busy === 1'b1)) ok = 1'b0;
        end
        arm = 1'b0;
        chk("hold_stable", 64'(ok), 64'd1);
        ack();
        photo_array[4] = 1'b0;
        tick(4);

        // Asynchronous reset in the middle of a window
        arm_tgt(4'd6, 32'd50, a);
        tick(5);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_hit", 64'(res_hit), 64'd0);
        chk("mid_rst_target", 64'(res_target), 64'd0);
        chk("mid_rst_score", 64'(score), 64'd0);
        chk("mid_rst_score_sat", 64'(score2), 64'd0);
        sc1 = 32'd0;
        sc2 = 32'd0;
        tick(2);
        reset = 1'b1;

        // Normal hit after reset
        arm_tgt(4'd1, 32'd30, a);
        exp_hit(4'd1);
        set_photo(1, 1'b1, p);
        wait_valid("post_rst_lat", p, 11);
        ack();
        photo_array[1] = 1'b0;
        tick(3);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
